iob_fifo_t2p_ctrl: RTL and testbench

IOB_FIFO_T2P_CTRL -- requirements
Module: iob_fifo_t2p_ctrl

---
 rtl/iob_fifo_t2p_ctrl.sv | 82 ++++++++
 tb/tb_iob_fifo_t2p_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/iob_fifo_t2p_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iob_fifo_t2p_ctrl : FIFO controller for an external two-port byte-enable RAM
// Rev 1.0
// ---------------------------------------------------------------------------
module iob_fifo_t2p_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  rst_i,
  input  logic                  w_en_i,
  input  logic [DATA_W-1:0]     w_data_i,
  output logic                  w_full_o,
  input  logic                  r_en_i,
  output logic [DATA_W-1:0]     r_data_o,
  output logic                  r_valid_o,
  output logic                  r_empty_o,
  output logic [ADDR_W:0]       level_o,
  output logic [DATA_W/8-1:0]   ext_mem_w_strb_o,
  output logic [ADDR_W-1:0]     ext_mem_w_addr_o,
  output logic [DATA_W-1:0]     ext_mem_w_data_o,
  output logic                  ext_mem_r_en_o,
  output logic [ADDR_W-1:0]     ext_mem_r_addr_o,
  input  logic [DATA_W-1:0]     ext_mem_r_data_i
);

  localparam logic [ADDR_W:0] C_FULL_LVL = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_level;
  logic              r_valid;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Flags come from the level register alone, so full/empty never depend on inputs.
  assign w_full   = (r_level == C_FULL_LVL);
  assign w_empty  = (r_level == '0);
  assign w_wr_acc = w_en_i & ~w_full  & ~rst_i;
  assign w_rd_acc = r_en_i & ~w_empty & ~rst_i;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_valid <= 1'b0;
    end else if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_rd_acc;
      if (w_wr_acc) r_wptr <= r_wptr + ADDR_W'(1);
      if (w_rd_acc) r_rptr <= r_rptr + ADDR_W'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
        2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign w_full_o         = w_full;
  assign r_empty_o        = w_empty;
  assign level_o          = r_level;
  assign r_valid_o        = r_valid;
  assign r_data_o         = ext_mem_r_data_i;
  assign ext_mem_w_strb_o = {(DATA_W/8){w_wr_acc}};
  assign ext_mem_w_addr_o = r_wptr;
  assign ext_mem_w_data_o = w_data_i;
  assign ext_mem_r_en_o   = w_rd_acc;
  assign ext_mem_r_addr_o = r_rptr;

endmodule
`default_nettype wire

// File: tb/tb_iob_fifo_t2p_ctrl.sv
`default_nettype none
// Bench for iob_fifo_t2p_ctrl: queue-based reference model plus directed scenarios.
module tb_iob_fifo_t2p_ctrl;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        rst;
  logic        w_en;
  logic [31:0] w_data;
  logic        w_full;
  logic        r_en;
  logic [31:0] r_data;
  logic        r_valid;
  logic        r_empty;
  logic [4:0]  level;
  logic [3:0]  m_strb;
  logic [3:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        m_ren;
  logic [3:0]  m_raddr;
  logic [31:0] m_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  iob_fifo_t2p_ctrl #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .rst_i(rst),
    .w_en_i(w_en), .w_data_i(w_data), .w_full_o(w_full),
    .r_en_i(r_en), .r_data_o(r_data), .r_valid_o(r_valid), .r_empty_o(r_empty),
    .level_o(level),
    .ext_mem_w_strb_o(m_strb), .ext_mem_w_addr_o(m_waddr), .ext_mem_w_data_o(m_wdata),
    .ext_mem_r_en_o(m_ren), .ext_mem_r_addr_o(m_raddr), .ext_mem_r_data_i(m_rdata)
  );

  // External byte-enable RAM with registered read port
  logic [31:0] ram [16];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (m_strb[b]) ram[m_waddr][8*b +: 8] <= m_wdata[8*b +: 8];
    if (m_ren) m_rdata <= ram[m_raddr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue; addresses are accept counts modulo depth.
  logic [31:0] mq[$];
  int          wcnt, rcnt;
  logic        mv;
  logic [31:0] mrd;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mq.delete(); wcnt = 0; rcnt = 0; mv = 1'b0;
    end else if (rst) begin
      mq.delete(); wcnt = 0; rcnt = 0; mv = 1'b0;
    end else begin
      bit aw, ar;
      aw = w_en && (mq.size() < 16);
      ar = r_en && (mq.size() > 0);
      mv = ar;
      if (ar) begin mrd = mq.pop_front(); rcnt++; end
      if (aw) begin mq.push_back(w_data); wcnt++; end
    end
  end

  always @(negedge clk) begin
    bit aw, ar;
    aw = w_en && !rst && (mq.size() < 16);
    ar = r_en && !rst && (mq.size() > 0);
    check("level", 64'(level), 64'(mq.size()));
    check("full",  64'(w_full), 64'(mq.size() == 16));
    check("empty", 64'(r_empty), 64'(mq.size() == 0));
    check("strb",  64'(m_strb), aw ? 64'hF : 64'h0);
    check("ren",   64'(m_ren), 64'(ar));
    check("valid", 64'(r_valid), 64'(mv));
    if (aw) begin
      check("waddr", 64'(m_waddr), 64'(wcnt % 16));
      check("wdata", 64'(m_wdata), 64'(w_data));
    end
    if (ar) check("raddr", 64'(m_raddr), 64'(rcnt % 16));
    if (mv) check("rdata", 64'(r_data), 64'(mrd));
  end

  task automatic step(input logic we, input logic [31:0] wd, input logic re);
    w_en = we; w_data = wd; r_en = re;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n = 1'b0; rst = 1'b0; w_en = 1'b0; r_en = 1'b0; w_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", 64'(level), 64'd0);
    check("rst_empty", 64'(r_empty), 64'd1);
    check("rst_full",  64'(w_full), 64'd0);
    check("rst_valid", 64'(r_valid), 64'd0);
    arst_n = 1'b1;

    // Fill to full
    for (int i = 1; i <= 16; i++) step(1'b1, 32'(i), 1'b0);
    check("fill_level", 64'(level), 64'd16);
    check("fill_full",  64'(w_full), 64'd1);
    w_en = 1'b1; w_data = 32'h11; r_en = 1'b0;
    @(negedge clk);
    check("ovf_strb", 64'(m_strb), 64'h0);
    @(posedge clk); #1;
    check("ovf_level", 64'(level), 64'd16);

    // Drain: data returns one cycle after each read, in order
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 32'h0, 1'b1);
      check("drain_valid", 64'(r_valid), 64'd1);
      check("drain_data",  64'(r_data), 64'(i));
    end
    check("drain_empty", 64'(r_empty), 64'd1);
    @(negedge clk);
    check("udf_ren", 64'(m_ren), 64'd0);
    @(posedge clk); #1;
    check("udf_valid", 64'(r_valid), 64'd0);

    // Level 5, then 20 cycles of simultaneous read/write across the wrap
    for (int i = 0; i < 5; i++) step(1'b1, 32'h100 + 32'(i), 1'b0);
    for (int k = 0; k < 20; k++) step(1'b1, 32'h200 + 32'(k), 1'b1);
    check("rw_level", 64'(level), 64'd5);

    // Fill, then both at full -> read only
    for (int i = 0; i < 11; i++) step(1'b1, 32'h300 + 32'(i), 1'b0);
    check("full2", 64'(w_full), 64'd1);
    step(1'b1, 32'hDEAD, 1'b1);
    check("both_full_level", 64'(level), 64'd15);
    for (int i = 0; i < 15; i++) step(1'b0, 32'h0, 1'b1);
    check("empty2", 64'(r_empty), 64'd1);
    step(1'b1, 32'h400, 1'b1);
    check("both_empty_level", 64'(level), 64'd1);

    // Soft clear at level 7 with a write pending
    for (int i = 0; i < 6; i++) step(1'b1, 32'h500 + 32'(i), 1'b0);
    check("lvl7", 64'(level), 64'd7);
    w_en = 1'b1; w_data = 32'h600; rst = 1'b1;
    @(negedge clk);
    check("clr_strb", 64'(m_strb), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("clr_level", 64'(level), 64'd0);
    check("clr_empty", 64'(r_empty), 64'd1);
    @(negedge clk);
    check("clr_waddr", 64'(m_waddr), 64'd0);
    @(posedge clk); #1;

    // Async reset at level 3 right after an accepted read
    for (int i = 0; i < 3; i++) step(1'b1, 32'h700 + 32'(i), 1'b0);
    step(1'b0, 32'h0, 1'b1);
    check("pre_arst_valid", 64'(r_valid), 64'd1);
    w_en = 1'b0; r_en = 1'b0;
    #1 arst_n = 1'b0;
    #1;
    check("arst_level", 64'(level), 64'd0);
    check("arst_empty", 64'(r_empty), 64'd1);
    check("arst_full",  64'(w_full), 64'd0);
    check("arst_valid", 64'(r_valid), 64'd0);
    @(posedge clk); #1;
    arst_n = 1'b1;
    w_en = 1'b1; w_data = 32'h800;
    @(negedge clk);
    check("arst_waddr", 64'(m_waddr), 64'd0);
    @(posedge clk); #1;
    w_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
